store_buffer: RTL and testbench

Commit-side store buffer for the multithreaded core. It receives stores that the writeback/commit logic retires through the `store_en`/`store_addr`/`store_isbyte`/`store_data` interface and holds them in program order. It drains them one at a time into the d-cache write port with a valid/ready handshake. It also answers same-cycle load lookups from the TL stage, so committed-but-undrained stores are forwarded or flagged as conflicts.

---
 rtl/store_buffer.sv | 84 ++++++++
 tb/tb_store_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order commit store FIFO draining to the d-cache, with same-cycle load forwarding and conflict detection.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       store_en,
  input  logic                       store_isbyte,
  input  logic [ADDR_W-1:0]          store_addr,
  input  logic [DATA_W-1:0]          store_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow_err,
  output logic                       drain_valid,
  input  logic                       drain_ready,
  output logic [ADDR_W-1:0]          drain_addr,
  output logic [DATA_W-1:0]          drain_data,
  output logic                       drain_isbyte,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic                       ld_isbyte,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_conflict
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  isbyte_q, valid_q;
  logic [PW-1:0]     head, tail;
  logic              pop, push;
  assign full         = count == FULL_C;
  assign empty        = count == '0;
  assign drain_valid  = !empty;
  assign drain_addr   = addr_q[head];
  assign drain_data   = data_q[head];
  assign drain_isbyte = isbyte_q[head];
  assign pop          = drain_valid && drain_ready;
  assign push         = store_en && (!full || pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid_q      <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (pop) head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop) valid_q[head] <= 1'b0;
      if (push) valid_q[tail] <= 1'b1;
      if (store_en && !push) overflow_err <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) begin
      addr_q[tail]   <= store_addr;
      data_q[tail]   <= store_data;
      isbyte_q[tail] <= store_isbyte;
    end
  // Walk oldest to youngest so the last overlapping entry wins.
  always_comb begin
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = head + PW'(i);
      if (valid_q[idx] && addr_q[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2] &&
          (!isbyte_q[idx] || !ld_isbyte || addr_q[idx][1:0] == ld_addr[1:0])) begin
        ld_conflict = isbyte_q[idx] && !ld_isbyte;
        ld_hit      = !ld_conflict;
        ld_data     = ld_conflict ? '0 :
                      !ld_isbyte  ? data_q[idx] :
                      isbyte_q[idx] ? DATA_W'(data_q[idx][7:0]) :
                      DATA_W'(data_q[idx][{ld_addr[1:0], 3'b000} +: 8]);
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        store_en = 1'b0, store_isbyte = 1'b0;
  logic [19:0] store_addr = '0;
  logic [31:0] store_data = '0;
  logic        full, empty, overflow_err, drain_valid, drain_isbyte;
  logic [2:0]  count;
  logic        drain_ready = 1'b0;
  logic [19:0] drain_addr;
  logic [31:0] drain_data;
  logic [19:0] ld_addr = '0;
  logic        ld_isbyte = 1'b0;
  logic        ld_hit, ld_conflict;
  logic [31:0] ld_data;
  int total = 0, bad = 0;
  store_buffer dut (
    .clk(clk), .rst(rst), .store_en(store_en), .store_isbyte(store_isbyte),
    .store_addr(store_addr), .store_data(store_data), .full(full), .empty(empty),
    .count(count), .overflow_err(overflow_err), .drain_valid(drain_valid),
    .drain_ready(drain_ready), .drain_addr(drain_addr), .drain_data(drain_data),
    .drain_isbyte(drain_isbyte), .ld_addr(ld_addr), .ld_isbyte(ld_isbyte),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic st(input logic [19:0] a, input logic [31:0] d, input logic b);
    store_en = 1'b1; store_addr = a; store_data = d; store_isbyte = b;
  endtask
  task automatic pulse_rst();
    rst = 1'b1; #2; rst = 1'b0;
  endtask
  initial begin
    #3 rst = 1'b1;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dvalid", drain_valid, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_ldhit", ld_hit, 0);
    chk("rst_ldconf", ld_conflict, 0);
    chk("rst_lddata", ld_data, 0);
    #3 rst = 1'b0;
    tick();
    // single store
    st(20'h00104, 32'hDEADBEEF, 0);
    tick();
    store_en = 1'b0;
    chk("single_valid", drain_valid, 1);
    chk("single_addr", drain_addr, 32'h00104);
    chk("single_data", drain_data, 32'hDEADBEEF);
    chk("single_count", count, 1);
    tick();
    chk("single_hold_addr", drain_addr, 32'h00104);
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
    chk("single_empty", empty, 1);
    chk("single_dvalid0", drain_valid, 0);
    // fill and overflow
    for (int i = 0; i < 4; i++) begin
      st(20'h10 + 20'(4*i), 32'hA0 + 32'(i), 0);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    chk("fill_ovf0", overflow_err, 0);
    st(20'h20, 32'hBAD, 0);
    tick();
    store_en = 1'b0;
    chk("ovf_set", overflow_err, 1);
    chk("ovf_count", count, 4);
    drain_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_order_addr", drain_addr, 32'h10 + 32'(4*i));
      chk("fill_order_data", drain_data, 32'hA0 + 32'(i));
      tick();
    end
    drain_ready = 1'b0;
    chk("fill_drained_empty", empty, 1);
    chk("ovf_sticky", overflow_err, 1);
    pulse_rst();
    chk("ovf_cleared", overflow_err, 0);
    tick();
    // full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      st(20'h40 + 20'(4*i), 32'hC0 + 32'(i), 0);
      tick();
    end
    chk("fwp_full", full, 1);
    st(20'h50, 32'hC4, 0);
    drain_ready = 1'b1;
    tick();
    store_en = 1'b0;
    chk("fwp_count", count, 4);
    chk("fwp_ovf", overflow_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk("fwp_order", drain_addr, 32'h44 + 32'(4*i));
      tick();
    end
    drain_ready = 1'b0;
    chk("fwp_empty", empty, 1);
    // forwarding
    st(20'h200, 32'h11223344, 0);
    tick();
    st(20'h201, 32'h000000AA, 1);
    ld_addr = 20'h200; ld_isbyte = 0;
    #1;
    chk("fwd_enq_not_seen_hit", ld_hit, 1);
    chk("fwd_enq_not_seen_data", ld_data, 32'h11223344);
    tick();
    store_en = 1'b0;
    chk("fwd_w200_conf", ld_conflict, 1);
    chk("fwd_w200_hit", ld_hit, 0);
    ld_addr = 20'h201; ld_isbyte = 1; #1;
    chk("fwd_b201_hit", ld_hit, 1);
    chk("fwd_b201_data", ld_data, 32'hAA);
    ld_addr = 20'h202; #1;
    chk("fwd_b202_hit", ld_hit, 1);
    chk("fwd_b202_data", ld_data, 32'h22);
    ld_addr = 20'h200; #1;
    chk("fwd_b200_data", ld_data, 32'h44);
    ld_addr = 20'h300; ld_isbyte = 0; #1;
    chk("fwd_w300_hit", ld_hit, 0);
    chk("fwd_w300_conf", ld_conflict, 0);
    chk("fwd_w300_data", ld_data, 0);
    ld_addr = 20'h203; ld_isbyte = 1;
    drain_ready = 1'b1; #1;
    chk("fwd_pop_visible", ld_data, 32'h11);
    tick();
    chk("fwd_after_pop_hit", ld_hit, 0);
    tick();
    drain_ready = 1'b0;
    chk("fwd_empty", empty, 1);
    // reset mid-drain
    for (int i = 0; i < 3; i++) begin
      st(20'h60 + 20'(4*i), 32'(i), 0);
      tick();
    end
    store_en = 1'b0;
    drain_ready = 1'b1;
    tick();
    chk("mid_head", drain_addr, 32'h64);
    chk("mid_count", count, 2);
    rst = 1'b1; #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_dvalid", drain_valid, 0);
    #1 rst = 1'b0;
    tick();
    tick();
    chk("mid_stay_idle", drain_valid, 0);
    st(20'h70, 32'h77, 0);
    drain_ready = 1'b0;
    tick();
    store_en = 1'b0;
    chk("mid_new_valid", drain_valid, 1);
    chk("mid_new_addr", drain_addr, 32'h70);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
